uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//  Consumes uart_rx byte strobes and assembles framed host commands into words for the accelerator.
//  Frame = SYNC, LEN (word count), LEN*WORD_BYTES payload bytes, CHK (XOR of LEN and all payload bytes).
//  Sits directly downstream of uart_rx and upstream of the accelerator's command input (valid/ready).
// PARAMETERS
//  WORD_BYTES      4       bytes per output word; o_Word width = 8*WORD_BYTES
//  MAX_WORDS       16      largest legal LEN; LEN==0 or LEN>MAX_WORDS is a frame error
//  SYNC_BYTE       8'hA5   start-of-frame marker
//  TIMEOUT_CYCLES  20000   inter-byte idle clocks mid-frame before abort (>= 2 byte times)
// PORTS
//  i_Clock       in   1               system clock, all logic on rising edge
//  reset         in   1               synchronous, active-high
//  i_Rx_DV       in   1               one-cycle byte strobe from uart_rx
//  i_Rx_Byte     in   8               received byte, valid when i_Rx_DV=1
//  o_Word        out  8*WORD_BYTES    assembled payload word
//  o_Word_Valid  out  1               o_Word held until accepted
//  i_Word_Ready  in   1               consumer accepts when o_Word_Valid & i_Word_Ready
//  o_Last        out  1               qualifies o_Word as final word of frame
//  o_Frame_Done  out  1               one-cycle pulse: CHK matched
//  o_Frame_Err   out  1               one-cycle pulse: bad LEN, CHK mismatch, overrun or timeout
//  o_Busy        out  1               high in any state other than S_HUNT
// BEHAVIOUR
//  Reset: state=S_HUNT; o_Word=0, o_Word_Valid=0, o_Last=0, o_Frame_Done=0, o_Frame_Err=0, o_Busy=0; reset dominates all.
//  FSM (advances only on i_Rx_DV, except timeout):
//   S_HUNT: byte==SYNC_BYTE -> S_LEN; all other bytes dropped silently.
//   S_LEN: 1<=byte<=MAX_WORDS -> latch word count, chk=byte, S_DATA; else Err pulse -> S_HUNT.
//   S_DATA: shift byte into assembly reg, chk^=byte; first byte -> bits[7:0] (little-endian).
//           Byte WORD_BYTES completes word: load o_Word, set o_Word_Valid, o_Last=(last word); last word -> S_CHK.
//           SYNC_BYTE inside payload is ordinary data.
//   S_CHK: byte==chk -> Done pulse; else Err pulse; both -> S_HUNT.
//  Latency: o_Word_Valid rises the cycle after the i_Rx_DV of the word's final byte; Done/Err the cycle after CHK's DV.
//  Handshake: o_Word/o_Last stable while o_Word_Valid & !i_Word_Ready; Valid drops the cycle after acceptance.
//   Acceptance and new-word load in the same cycle: legal, Valid stays 1 with new data.
//  Overrun: word completes while previous word unaccepted -> Err pulse, pending word kept, new word discarded, -> S_HUNT.
//  Timeout: idle counter clears on every i_Rx_DV and in S_HUNT; reaching TIMEOUT_CYCLES outside S_HUNT
//   -> Err pulse, S_HUNT, partial word discarded. DV in expiry cycle wins (byte processed, no error).
//  Words already emitted are not retracted on error; consumer discards frame on o_Frame_Err.
//  Done/Err never both high; Err asserts at most once per frame.
//  Counters: byte index $clog2(WORD_BYTES) bits, word count $clog2(MAX_WORDS+1) bits, no wrap possible.
// STRUCTURE
//  uart_defs.vh: SYNC_BYTE default, FSM state encodings (S_HUNT,S_LEN,S_DATA,S_CHK), error-cause codes.
//  Sub-module uart_byte_timer: idle counter with clear/enable and one-cycle expire output.
//  Remainder (FSM, assembly shift reg, XOR accumulator, output register) flat in uart_rx_framer.
// TESTING (uart_tx -> uart_rx -> uart_rx_framer, i_Word_Ready=1 unless stated)
//  1 A5 01 11 22 33 44 CHK=01^11^22^33^44=45 -> o_Word=32'h44332211 with o_Last=1, then o_Frame_Done pulse.
//  2 Bytes 00 5A A5 02, eight data bytes, correct CHK -> leading 00 5A ignored; 2 words, Last only on 2nd, Done.
//  3 Same as 1 but CHK=46 -> word still emitted, o_Frame_Err pulse, no Done; next good frame accepted.
//  4 A5 00 and A5 11 (>MAX_WORDS) -> Err after LEN byte, o_Busy=0, following payload bytes ignored until SYNC.
//  5 LEN=2, i_Word_Ready=0 throughout -> first word held stable, Err on second word's last byte, first word unchanged.
//  6 A5 01 11 then silence TIMEOUT_CYCLES -> Err, o_Busy=0; also reset asserted mid-S_DATA -> all outputs zero next cycle.

Source files
------------

// File: rtl/uart_rx_framer_pkg.sv
// Shared defaults, FSM/error encodings and the LEN legality check for the UART command framer.
package uart_rx_framer_pkg;

    localparam int         DEF_WORD_BYTES     = 4;
    localparam int         DEF_MAX_WORDS      = 16;
    localparam logic [7:0] DEF_SYNC_BYTE      = 8'hA5;
    localparam int         DEF_TIMEOUT_CYCLES = 20000;

    typedef enum logic [1:0] {
        S_HUNT,
        S_LEN,
        S_DATA,
        S_CHK
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_LEN,
        ERR_CHK,
        ERR_OVERRUN,
        ERR_TIMEOUT
    } err_cause_e;

    function automatic logic len_ok(input logic [7:0] len, input int max_words);
        return (len != 8'd0) && (int'(len) <= max_words);
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter: clear wins over enable, expire_o pulses once per TIMEOUT_CYCLES idle clocks.
module uart_byte_timer #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_last;

    assign at_last  = (count_q == CNT_LAST);
    assign expire_o = enable_i && !clear_i && at_last;

    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = at_last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// Assembles SYNC/LEN/payload/CHK frames from uart_rx byte strobes into little-endian words
// presented on a valid/ready port, with Done/Err pulses per frame.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int         WORD_BYTES     = DEF_WORD_BYTES,
    parameter int         MAX_WORDS      = DEF_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    i_Clock,
    input  logic                    reset,
    input  logic                    i_Rx_DV,
    input  logic [7:0]              i_Rx_Byte,
    output logic [8*WORD_BYTES-1:0] o_Word,
    output logic                    o_Word_Valid,
    input  logic                    i_Word_Ready,
    output logic                    o_Last,
    output logic                    o_Frame_Done,
    output logic                    o_Frame_Err,
    output logic                    o_Busy
);

    // WORD_BYTES must be at least 2: the assembly register holds all but the final byte.
    localparam int                W         = 8 * WORD_BYTES;
    localparam int                BIDX_W    = $clog2(WORD_BYTES);
    localparam int                WCNT_W    = $clog2(MAX_WORDS + 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_BYTES - 1);

    state_e              state_q;
    logic [BIDX_W-1:0]   byte_idx_q;
    logic [WCNT_W-1:0]   words_left_q;
    logic [7:0]          chk_q;
    logic [W-9:0]        asm_q;
    logic [W-1:0]        word_q;
    logic                valid_q;
    logic                last_q;
    logic                done_q;
    logic                err_q;

    logic [W-1:0]        asm_next;
    logic                word_done;
    logic                word_pending;
    logic                last_word;
    logic                tmr_expire;
    err_cause_e          err_cause;

    assign asm_next     = {i_Rx_Byte, asm_q};
    assign word_done    = (byte_idx_q == BIDX_LAST);
    assign word_pending = valid_q && !i_Word_Ready;
    assign last_word    = (words_left_q == WCNT_W'(1));

    uart_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (i_Clock),
        .rst_i    (reset),
        .clear_i  (i_Rx_DV || (state_q == S_HUNT)),
        .enable_i (state_q != S_HUNT),
        .expire_o (tmr_expire)
    );

    // A byte arriving in the expiry cycle is processed; timeout only applies to an idle cycle.
    always_comb begin
        err_cause = ERR_NONE;
        if (i_Rx_DV) begin
            unique case (state_q)
                S_LEN:   if (!len_ok(i_Rx_Byte, MAX_WORDS)) err_cause = ERR_LEN;
                S_DATA:  if (word_done && word_pending)     err_cause = ERR_OVERRUN;
                S_CHK:   if (i_Rx_Byte != chk_q)            err_cause = ERR_CHK;
                default: err_cause = ERR_NONE;
            endcase
        end else if (tmr_expire) begin
            err_cause = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state_q      <= S_HUNT;
            byte_idx_q   <= '0;
            words_left_q <= '0;
            chk_q        <= '0;
            word_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (valid_q && i_Word_Ready) begin
                valid_q <= 1'b0;
            end

            if (err_cause != ERR_NONE) begin
                // A pending word stays on the output; the consumer drops the frame on Err.
                err_q   <= 1'b1;
                state_q <= S_HUNT;
            end else if (i_Rx_DV) begin
                unique case (state_q)
                    S_HUNT: begin
                        if (i_Rx_Byte == SYNC_BYTE) begin
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        words_left_q <= WCNT_W'(i_Rx_Byte);
                        chk_q        <= i_Rx_Byte;
                        byte_idx_q   <= '0;
                        state_q      <= S_DATA;
                    end
                    S_DATA: begin
                        chk_q <= chk_q ^ i_Rx_Byte;
                        if (word_done) begin
                            byte_idx_q   <= '0;
                            word_q       <= asm_next;
                            valid_q      <= 1'b1;
                            last_q       <= last_word;
                            words_left_q <= words_left_q - WCNT_W'(1);
                            if (last_word) begin
                                state_q <= S_CHK;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + BIDX_W'(1);
                        end
                    end
                    S_CHK: begin
                        done_q  <= 1'b1;
                        state_q <= S_HUNT;
                    end
                    default: state_q <= S_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        // NOTE: asm_q is left unreset on purpose; every word is fully shifted in before it is used.
        if (i_Rx_DV && (state_q == S_DATA)) begin
            asm_q <= asm_next[W-1:8];
        end
    end

    assign o_Word       = word_q;
    assign o_Word_Valid = valid_q;
    assign o_Last       = last_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;
    assign o_Busy       = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: frames are built from payload lists, expected events are
// queued at construction time and a negedge monitor pops and compares what the DUT presents.
module tb_uart_rx_framer;

    localparam int         WB   = 4;
    localparam int         MW   = 16;
    localparam int         TO   = 300;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          i_Clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_Rx_DV = 1'b0;
    logic [7:0]    i_Rx_Byte = 8'h00;
    logic [8*WB-1:0] o_Word;
    logic          o_Word_Valid;
    logic          i_Word_Ready;
    logic          o_Last;
    logic          o_Frame_Done;
    logic          o_Frame_Err;
    logic          o_Busy;

    always #5 i_Clock = ~i_Clock;

    uart_rx_framer #(
        .WORD_BYTES    (WB),
        .MAX_WORDS     (MW),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_Clock     (i_Clock),
        .reset       (reset),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Word      (o_Word),
        .o_Word_Valid(o_Word_Valid),
        .i_Word_Ready(i_Word_Ready),
        .o_Last      (o_Last),
        .o_Frame_Done(o_Frame_Done),
        .o_Frame_Err (o_Frame_Err),
        .o_Busy      (o_Busy)
    );

    typedef enum int {EV_WORD, EV_DONE, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] word;
        logic        last;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  rdy_rand = 1'b0;
    bit  rdy_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input ev_kind_e k, input logic [31:0] w, input logic l);
        ev_t e;
        e.kind = k;
        e.word = w;
        e.last = l;
        exp_q.push_back(e);
    endfunction

    function automatic int rgap(input int mx);
        return (mx == 0) ? 0 : int'($urandom_range(0, mx));
    endfunction

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        b = 8'($urandom);
        return (b == SYNC) ? 8'h00 : b;
    endfunction

    // Called at posedge+1; the strobe is sampled on the next edge, then `gap` idle edges follow.
    task automatic send_byte(input logic [7:0] b, input int gap);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(posedge i_Clock);
        #1;
        i_Rx_DV = 1'b0;
        repeat (gap) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    // Sends SYNC, LEN, payload, CHK^chk_flip and queues the events the frame must produce.
    task automatic frame(input logic [7:0] p[$], input logic [7:0] chk_flip, input int gap_max);
        int          nw;
        logic [7:0]  chk;
        logic [31:0] w;
        nw  = p.size() / WB;
        chk = 8'(nw);
        foreach (p[i]) chk ^= p[i];
        chk ^= chk_flip;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < WB; k++) w[8*k +: 8] = p[i*WB + k];
            push_ev(EV_WORD, w, (i == nw - 1));
        end
        push_ev((chk_flip != 8'h00) ? EV_ERR : EV_DONE, '0, 1'b0);
        send_byte(SYNC, rgap(gap_max));
        send_byte(8'(nw), rgap(gap_max));
        foreach (p[i]) send_byte(p[i], rgap(gap_max));
        send_byte(chk, rgap(gap_max));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    // Consumer: forced level, or random stalls never longer than one cycle.
    initial begin
        i_Word_Ready = 1'b1;
        forever begin
            @(posedge i_Clock);
            #2;
            if (!rdy_rand)          i_Word_Ready = rdy_force;
            else if (!i_Word_Ready) i_Word_Ready = 1'b1;
            else                    i_Word_Ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic sb_pop(input ev_kind_e k, input logic [31:0] w, input logic l);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: DUT event kind=%0d word=%h with nothing expected (t=%0t)", k, w, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", k, e.kind);
            if (k == EV_WORD && e.kind == EV_WORD) begin
                check("sb_word", w, e.word);
                check("sb_last", l, e.last);
            end
        end
    endtask

    always @(negedge i_Clock) begin
        if (!reset) begin
            if (o_Frame_Done || o_Frame_Err) check("done_err_exclusive", o_Frame_Done & o_Frame_Err, 0);
            if (o_Word_Valid && i_Word_Ready) sb_pop(EV_WORD, o_Word, o_Last);
            if (o_Frame_Done) sb_pop(EV_DONE, '0, 1'b0);
            if (o_Frame_Err)  sb_pop(EV_ERR, '0, 1'b0);
        end
    end

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [7:0] p[$];
        int         elapsed;
        bit         seen;
        int         kind;
        int         len;

        repeat (3) @(posedge i_Clock);
        #1;
        check("rst_word", o_Word, 0);
        check("rst_valid", o_Word_Valid, 0);
        check("rst_last", o_Last, 0);
        check("rst_done", o_Frame_Done, 0);
        check("rst_err", o_Frame_Err, 0);
        check("rst_busy", o_Busy, 0);
        reset = 1'b0;
        idle(2);

        // 1: single-word frame with latency checks
        push_ev(EV_WORD, 32'h44332211, 1'b1);
        push_ev(EV_DONE, '0, 1'b0);
        send_byte(SYNC, 1);
        check("t1_busy", o_Busy, 1);
        send_byte(8'h01, 2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        check("t1_valid_early", o_Word_Valid, 0);
        send_byte(8'h44, 0);
        check("t1_valid", o_Word_Valid, 1);
        check("t1_word", o_Word, 32'h44332211);
        check("t1_last", o_Last, 1);
        send_byte(8'h45, 0);
        check("t1_done", o_Frame_Done, 1);
        idle(3);

        // 2: leading junk then a two-word frame
        send_byte(8'h00, 1);
        send_byte(8'h5A, 1);
        p = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        frame(p, 8'h00, 1);
        idle(3);

        // 3: bad CHK (0x46), then a good frame; plus SYNC bytes as payload
        p = '{8'h11, 8'h22, 8'h33, 8'h44};
        frame(p, 8'h03, 0);
        idle(2);
        frame(p, 8'h00, 2);
        p = '{SYNC, SYNC, SYNC, SYNC};
        frame(p, 8'h00, 0);
        idle(3);

        // 4: illegal LEN values, payload ignored until next SYNC
        push_ev(EV_ERR, '0, 1'b0);
        send_byte(SYNC, 1);
        send_byte(8'h00, 0);
        check("t4_err_len0", o_Frame_Err, 1);
        check("t4_busy_len0", o_Busy, 0);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        push_ev(EV_ERR, '0, 1'b0);
        send_byte(SYNC, 0);
        send_byte(8'h11, 0);
        check("t4_err_len17", o_Frame_Err, 1);
        check("t4_busy_len17", o_Busy, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
        check("t4_busy_after_junk", o_Busy, 0);
        p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        frame(p, 8'h00, 0);
        idle(3);

        // 5: consumer stalled, second word overruns
        rdy_force = 1'b0;
        push_ev(EV_ERR, '0, 1'b0);
        push_ev(EV_WORD, 32'h04030201, 1'b0);
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
        check("t5_valid1", o_Word_Valid, 1);
        check("t5_word1", o_Word, 32'h04030201);
        check("t5_last1", o_Last, 0);
        for (int i = 5; i <= 8; i++) send_byte(8'(i), 1);
        idle(0);
        send_byte(8'h0B, 2);
        check("t5_word_held", o_Word, 32'h04030201);
        check("t5_valid_held", o_Word_Valid, 1);
        check("t5_busy", o_Busy, 0);
        rdy_force = 1'b1;
        idle(3);
        check("t5_valid_drop", o_Word_Valid, 0);

        // 7: acceptance and new-word load in the same cycle
        rdy_force = 1'b0;
        push_ev(EV_WORD, 32'hA4A3A2A1, 1'b0);
        push_ev(EV_WORD, 32'hB4B3B2B1, 1'b1);
        push_ev(EV_DONE, '0, 1'b0);
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        send_byte(8'hA3, 0);
        send_byte(8'hA4, 2);
        send_byte(8'hB1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hB3, 0);
        rdy_force = 1'b1;
        send_byte(8'hB4, 0);
        check("t7_valid_kept", o_Word_Valid, 1);
        check("t7_word2", o_Word, 32'hB4B3B2B1);
        send_byte(8'h02 ^ 8'hA1 ^ 8'hA2 ^ 8'hA3 ^ 8'hA4 ^ 8'hB1 ^ 8'hB2 ^ 8'hB3 ^ 8'hB4, 3);

        // 6: inter-byte timeout
        push_ev(EV_ERR, '0, 1'b0);
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        elapsed = 0;
        seen    = 1'b0;
        while (!seen && elapsed < 2 * TO) begin
            @(posedge i_Clock);
            #1;
            elapsed++;
            if (o_Frame_Err) seen = 1'b1;
        end
        check("t6_timeout_seen", seen, 1);
        check("t6_timeout_latency_ok", (elapsed >= TO && elapsed <= TO + 1), 1);
        check("t6_busy", o_Busy, 0);
        idle(2);

        // byte arriving in the expiry cycle is accepted
        push_ev(EV_WORD, 32'h44332211, 1'b1);
        push_ev(EV_DONE, '0, 1'b0);
        send_byte(SYNC, 0);
        send_byte(8'h01, TO - 1);
        send_byte(8'h11, TO - 1);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h45, 2);

        // reset mid-S_DATA with a pending word
        rdy_force = 1'b0;
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        check("rst2_busy_before", o_Busy, 1);
        check("rst2_valid_before", o_Word_Valid, 1);
        reset = 1'b1;
        @(posedge i_Clock);
        #1;
        check("rst2_word", o_Word, 0);
        check("rst2_valid", o_Word_Valid, 0);
        check("rst2_last", o_Last, 0);
        check("rst2_done", o_Frame_Done, 0);
        check("rst2_err", o_Frame_Err, 0);
        check("rst2_busy", o_Busy, 0);
        reset     = 1'b0;
        rdy_force = 1'b1;
        idle(2);

        // randomized frames with random consumer stalls
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) send_byte(noise_byte(), rgap(2));
            kind = int'($urandom_range(0, 9));
            if (kind < 8) begin
                len = int'($urandom_range(1, MW));
                p = {};
                for (int i = 0; i < len * WB; i++)
                    p.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
                frame(p, (kind < 6) ? 8'h00 : 8'($urandom_range(1, 255)), 3);
            end else begin
                push_ev(EV_ERR, '0, 1'b0);
                send_byte(SYNC, rgap(3));
                send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MW + 1, 255)), rgap(3));
                repeat ($urandom_range(0, 3)) send_byte(noise_byte(), rgap(3));
            end
        end
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        idle(10);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
